// File: rtl/pipelined_addsub_if.sv
// Valid/ready bundle for the pipelined adder/subtractor.
// master drives operands and out_ready; slave returns in_ready and the result.
interface pipelined_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined add/sub: CHUNK bits per stage, carry registered between stages.
// Ports: clk, rst (sync, active-high), bus (slave: operands in, result out).
module pipelined_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic               clk,
  input  logic               rst,
  pipelined_addsub_if.slave  bus
);
  localparam int STAGES = (CHUNK < 1) ? 1 : WIDTH / CHUNK;

  if (CHUNK < 1) begin : g_bad_chunk
    $error("CHUNK must be at least 1");
  end else if (WIDTH % CHUNK != 0) begin : g_bad_width
    $error("WIDTH must be a multiple of CHUNK");
  end
  if ($bits(bus.sum) != WIDTH) begin : g_bad_bus
    $error("interface WIDTH does not match");
  end

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] sb_q;
  logic [WIDTH-1:0]  res_q [STAGES];
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic              ovf_q;

  logic [STAGES:0]   take;
  logic [WIDTH-1:0]  pa [STAGES];
  logic [WIDTH-1:0]  pb [STAGES];
  logic [WIDTH-1:0]  pr [STAGES];
  logic [WIDTH-1:0]  nr [STAGES];
  logic [STAGES-1:0] pc;
  logic [STAGES-1:0] pv;
  logic [STAGES-1:0] ps;
  logic [STAGES-1:0] nc;
  logic [CHUNK:0]    add;
  logic              ovf_n;

  // A stage can load when empty or when its content moves on.
  always_comb begin
    take = '0;
    take[STAGES] = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      take[k] = !v_q[k] || take[k+1];
    end
  end

  always_comb begin
    pa[0] = bus.a;
    pb[0] = bus.sub ? ~bus.b : bus.b;
    pc[0] = bus.sub ^ bus.cin;
    pr[0] = '0;
    pv[0] = bus.in_valid;
    ps[0] = bus.sub;
    for (int k = 1; k < STAGES; k++) begin
      pa[k] = a_q[k-1];
      pb[k] = b_q[k-1];
      pc[k] = c_q[k-1];
      pr[k] = res_q[k-1];
      pv[k] = v_q[k-1];
      ps[k] = sb_q[k-1];
    end
    add = '0;
    nc  = '0;
    for (int k = 0; k < STAGES; k++) begin
      add = {1'b0, pa[k][k*CHUNK +: CHUNK]}
          + {1'b0, pb[k][k*CHUNK +: CHUNK]}
          + {{CHUNK{1'b0}}, pc[k]};
      nr[k] = pr[k];
      nr[k][k*CHUNK +: CHUNK] = add[CHUNK-1:0];
      nc[k] = add[CHUNK];
    end
    // Carry into the MSB recovered from its sum bit.
    ovf_n = pa[STAGES-1][WIDTH-1] ^ pb[STAGES-1][WIDTH-1]
          ^ nr[STAGES-1][WIDTH-1] ^ nc[STAGES-1];
  end

  // Bubbles clear v only; data regs keep their last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      c_q   <= '0;
      sb_q  <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        res_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (take[k]) begin
          v_q[k] <= pv[k];
          if (pv[k]) begin
            res_q[k] <= nr[k];
            a_q[k]   <= pa[k];
            b_q[k]   <= pb[k];
            c_q[k]   <= nc[k];
            sb_q[k]  <= ps[k];
          end
        end
      end
      if (take[STAGES-1] && pv[STAGES-1]) begin
        ovf_q <= ovf_n;
      end
    end
  end

  assign bus.in_ready  = take[0];
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.sum       = res_q[STAGES-1];
  assign bus.cout      = c_q[STAGES-1] ^ sb_q[STAGES-1];
  assign bus.ovf       = ovf_q;
endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined successor to the 4-bit full adder.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per stage, passing the carry between stages in registers.
- Uses a valid/ready handshake on input and output, accepts one operation per cycle and supports backpressure.
- Serves as the shared arithmetic core for the lab datapath (accumulators, ALU, BCD front-ends).

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits added per pipeline stage; STAGES = WIDTH/CHUNK; CHUNK = WIDTH gives a single stage.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands this cycle
a  input  WIDTH  operand A (unsigned or two's complement)
b  input  WIDTH  operand B
cin  input  1  carry-in (add) or borrow-in (sub)
sub  input  1  0: a+b+cin; 1: a-b-cin
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result modulo 2^WIDTH
cout  output  1  add: carry-out; sub: borrow-out (1 when a < b+cin unsigned)
ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset: rst is sampled on rising clk and takes priority over all other inputs.
  - Reset clears every stage valid bit, so out_valid=0 and in_ready=1 in the cycle after reset.
  - Reset sets sum=0, cout=0, ovf=0. Data registers are also cleared.
- Reset mid-operation: all in-flight operations are discarded; none appears at the output.
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Stage k (0..STAGES-1) holds:
  - valid bit v[k];
  - registered carry c[k];
  - result chunks 0..k;
  - the remaining upper operand chunks, with B already conditionally inverted;
  - the sub flag.
- Stage 0 computation at input transfer:
  - Effective B = sub ? ~b : b.
  - Carry into chunk 0 = sub ? ~cin : cin.
  - Stage 0 computes chunk 0.
- Stage k>0 computes chunk k = A_k + B_k + c[k-1]. Lower result chunks shift forward unchanged.
- The last stage drives sum, cout and ovf directly from registers:
  - sum = concatenation of all chunks;
  - cout = final carry XOR sub;
  - ovf = carry into MSB XOR carry out of MSB, computed in the last stage.
- Latency: operands accepted at edge N appear with out_valid=1 after edge N+STAGES-1 (STAGES cycles counted inclusively). With defaults, latency is 4.
- Throughput is one operation per cycle when out_ready stays 1.
- Backpressure:
  - Stage k may load when !v[k] || advance[k+1]. The last stage's advance is out_ready.
  - in_ready = !v[0] || advance[1]; it is combinational from out_ready through the stage chain.
  - A stalled stage holds all of its registers stable.
  - A stage with v=0 may take a bubble.
- Output stability: while out_valid=1 && out_ready=0, sum, cout and ovf must not change.
- Simultaneous accept and drain in the same cycle are both honoured; no bubble is inserted.
- Results leave strictly in input order; no operation is dropped or duplicated.
- No combinational path from a, b or cin to sum, cout or ovf.
- Data outputs after a drain with no new input hold their last value; only out_valid qualifies them.
- Elaboration must fail if WIDTH % CHUNK != 0 or CHUNK < 1.

Test Plan:
- Reset, then in_valid=0 for 10 cycles -> out_valid=0, in_ready=1, sum=0 throughout.
- WIDTH=16, CHUNK=4: a=0xFFFF, b=0x0001, cin=0, sub=0, out_ready=1 -> after 4 cycles sum=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- Subtract: a=0x0003, b=0x0005, cin=0, sub=1 -> sum=0xFFFE, cout=1 (borrow), ovf=0; a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=0, ovf=1; a=5, b=2, cin=1, sub=1 -> sum=2, cout=0.
- Streaming: 100 back-to-back random ops with out_ready=1 -> one result per cycle in order, each matching the reference model (a±b±cin), latency exactly 4.
- Backpressure: random out_ready (50%), random in_valid -> outputs stable while stalled, in_ready=0 when all 4 stages full and out_ready=0, no loss or reorder over 1000 ops.
- Assert rst with 3 ops in flight -> next cycle out_valid=0, in_ready=1; none of the 3 results ever appears. Repeat with CHUNK=WIDTH=8 -> latency 1.
